mul_seq_16bit: RTL and testbench

- Sequential radix-2 shift-add unsigned multiplier, 16x16 -> 32.
- Sits directly upstream of and around the 16-bit carry-lookahead adder (CLA_16bit). It feeds the adder one partial-product addition per cycle and consumes its sum and carry-out.
- Provides the MUL datapath for the ALU with valid/ready handshakes on both sides.

---
 rtl/mul_seq_16bit_if.sv | 28 ++
 rtl/mul_seq_16bit.sv | 147 ++++++++++++++
 tb/tb_mul_seq_16bit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_16bit_if.sv
// mul_seq_16bit_if: operand/product handshake bundle for the sequential multiplier.
//   in_valid  (master->slave)  operands a/b present
//   in_ready  (slave->master)  multiplier idle, can take operands
//   a, b      (master->slave)  unsigned multiplicand / multiplier
//   out_valid (slave->master)  product p valid
//   out_ready (master->slave)  consumer takes the product
//   p         (slave->master)  unsigned product a*b
interface mul_seq_16bit_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p
  );
endinterface

// File: rtl/mul_seq_16bit.sv
// mul_seq_16bit: radix-2 shift-add unsigned multiplier, 16x16 -> 32.
// One partial-product addition per cycle through a 16-bit carry-lookahead
// adder; 16 steps per operation, fixed latency, valid/ready on both sides.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  slave side of mul_seq_16bit_if (in_valid/in_ready/a/b in,
//        out_valid/out_ready/p out)
// WIDTH is fixed at 16 (the adder is a fixed 16-bit structure) and
// CNT_W must satisfy 2**CNT_W == WIDTH.
module mul_seq_16bit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input logic           clk,
  input logic           rst,
  mul_seq_16bit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_mq;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic               w_step;
  logic [WIDTH-1:0]   w_add_b;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;

  // ---------------------------------------------------------------------------
  // Control: state register and next-state / step decode
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        // Last of the 16 steps: counter has reached all-ones.
        if (r_cnt == {CNT_W{1'b1}}) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Adder stage: 16-bit carry-lookahead adder, 4 groups of 4 bits with a
  // second lookahead level across the groups. Only adder on the datapath.
  // ---------------------------------------------------------------------------
  assign w_add_b = r_mq[0] ? r_mcand : '0;

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_c;
  logic [3:0]       w_gg;
  logic [3:0]       w_gp;
  logic [4:0]       w_gc;

  assign w_g = r_acc_hi & w_add_b;
  assign w_p = r_acc_hi ^ w_add_b;

  always_comb begin
    w_gg = '0;
    w_gp = '0;
    w_gc = '0;
    w_c  = '0;
    for (int k = 0; k < 4; k++) begin
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | ((&w_p[4*k+1 +: 3]) & w_g[4*k]);
      w_gp[k] = &w_p[4*k +: 4];
    end
    // Carry-in is tied low: each step is a plain acc_hi + partial product.
    w_gc[0] = 1'b0;
    w_gc[1] = w_gg[0];
    w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]);
    w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | ((&w_gp[2:1]) & w_gg[0]);
    w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | ((&w_gp[3:2]) & w_gg[1])
            | ((&w_gp[3:1]) & w_gg[0]);
    for (int k = 0; k < 4; k++) begin
      w_c[4*k]   = w_gc[k];
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
    end
  end

  assign w_sum  = w_p ^ w_c;
  assign w_cout = w_gc[4];

  // ---------------------------------------------------------------------------
  // Datapath registers: load on accept, shift-add on each RUN step
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_mq     <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_mcand  <= bus.a;
      r_mq     <= bus.b;
      r_acc_hi <= '0;
      r_cnt    <= '0;
    end else if (w_step) begin
      // Carry-out becomes the new MSB of acc_hi; the retired multiplier bit
      // falls off the bottom of mq while the sum LSB enters its top.
      {r_acc_hi, r_mq} <= {w_cout, w_sum, r_mq[WIDTH-1:1]};
      r_cnt            <= r_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from registered state
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.p         = {r_acc_hi, r_mq};

endmodule

// File: tb/tb_mul_seq_16bit.sv
module tb_mul_seq_16bit;

  logic clk;
  logic rst;

  mul_seq_16bit_if #(.WIDTH(16)) bus ();

  mul_seq_16bit #(.WIDTH(16), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp_p;
  } vec_t;

  vec_t vecs[5];

  // Behavioural reference: the product as plain arithmetic.
  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    return 32'(x) * 32'(y);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // Present operands for one cycle; returns at the negedge after the accept edge.
  task automatic start_op(input logic [15:0] op_a, input logic [15:0] op_b);
    @(negedge clk);
    check("accept_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = op_a;
    bus.b        = op_b;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    // Operand changes while running must not disturb the result.
    bus.a        = 16'($urandom);
    bus.b        = 16'($urandom);
  endtask

  // Count edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_and_check(input string nm, input logic [15:0] op_a,
                               input logic [15:0] op_b, input logic [31:0] exp_v);
    int lat;
    bus.out_ready = 1'b1;
    start_op(op_a, op_b);
    wait_done(lat);
    check({nm, "_lat"}, 32'(lat), 32'd16);
    check({nm, "_p"}, bus.p, exp_v);
    @(negedge clk);
    check({nm, "_idle_rdy"}, 32'(bus.in_ready), 32'd1);
    check({nm, "_idle_vld"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int          lat;
    logic [15:0] ra, rb;
    logic [31:0] held;
    bit          seen;
    logic [15:0] pa[3];
    logic [15:0] pb[3];
    int          acc_cyc[$];
    logic [31:0] got[$];
    int          idx;
    int          cyc;
    bit          will;

    vecs[0] = '{16'h1234, 16'h5678, 32'h06260060};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[2] = '{16'hFFFF, 16'h0003, 32'h0002FFFD};
    vecs[3] = '{16'h0000, 16'hABCD, 32'h00000000};
    vecs[4] = '{16'h8000, 16'h0002, 32'h00010000};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = '0;
    bus.b         = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_p", bus.p, 32'h0);
    check("rst_vld", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rdy", 32'(bus.in_ready), 32'd1);

    // Directed vectors
    for (int i = 0; i < 5; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_p);

    // Random operands against the reference model
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_and_check($sformatf("rnd%0d", i), ra, rb, ref_mul(ra, rb));
    end

    // Backpressure in DONE with new operands offered
    bus.out_ready = 1'b0;
    start_op(16'hABCD, 16'h0010);
    wait_done(lat);
    check("bp_lat", 32'(lat), 32'd16);
    check("bp_p", bus.p, 32'h000ABCD0);
    held = bus.p;
    bus.in_valid = 1'b1;
    bus.a        = 16'h0001;
    bus.b        = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_vld", 32'(bus.out_valid), 32'd1);
      check("bp_hold_p", bus.p, held);
      check("bp_hold_rdy", 32'(bus.in_ready), 32'd0);
      bus.a = bus.a + 16'd3;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_rdy", 32'(bus.in_ready), 32'd1);
    check("bp_rel_vld", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("bp_no_accept", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of a run
    start_op(16'h00FF, 16'h0101);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_p_async", bus.p, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_rdy", 32'(bus.in_ready), 32'd1);
    check("abort_p", bus.p, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("abort_no_vld", 32'(seen), 32'd0);
    run_and_check("after_abort", 16'h0003, 16'h0005, 32'h0000000F);

    // Back-to-back with in_valid and out_ready held high
    pa[0] = 16'($urandom); pb[0] = 16'($urandom);
    pa[1] = 16'hFFFF;      pb[1] = 16'h8001;
    pa[2] = 16'($urandom); pb[2] = 16'($urandom);
    idx = 0;
    cyc = 0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = pa[0];
    bus.b        = pb[0];
    while (got.size() < 3 && cyc < 200) begin
      will = bus.in_valid && bus.in_ready;
      if (bus.out_valid) got.push_back(bus.p);
      @(posedge clk);
      cyc++;
      if (will) begin
        acc_cyc.push_back(cyc);
        idx++;
        #1;
        if (idx < 3) begin
          bus.a = pa[idx];
          bus.b = pb[idx];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    check("b2b_results", 32'(got.size()), 32'd3);
    check("b2b_accepts", 32'(acc_cyc.size()), 32'd3);
    for (int i = 0; i < got.size() && i < 3; i++)
      check($sformatf("b2b_p%0d", i), got[i], ref_mul(pa[i], pb[i]));
    for (int i = 1; i < acc_cyc.size(); i++)
      check($sformatf("b2b_gap%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
